comp_track_param: RTL
=====================

# comp_track_param

Parametrised, registered magnitude comparator with runtime signed/unsigned mode and a running min/max tracker. It compares a stream of operand pairs (a, b) at one pair per cycle and outputs a one-hot greater/equal/less result one cycle later. It also tracks the extreme values of `a` and counts how often a > b and a == b since the last clear. It sits in the lab datapath wherever the fixed 4-bit combinational comparator is too narrow or a result history is needed.

## Interface
Parameters:
- WIDTH, 8: operand width in bits (≥ 2).
- CNT_W, 8: width of the event counters (≥ 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, **asynchronous, active-high**.
- in_valid  input  1  a/b/signed_mode are sampled this cycle.
- signed_mode  input  1  1 = two's-complement compare; 0 = unsigned compare.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- clear  input  1  synchronous clear of the tracker and counters.
- out_valid  output  1  one-cycle pulse; result flags are for the pair accepted on the previous cycle.
- a_gt_b  output  1  registered A > B.
- a_eq_b  output  1  registered A == B.
- a_lt_b  output  1  registered A < B.
- max_a  output  WIDTH  largest `a` seen since clear, under the sample's own mode.
- min_a  output  WIDTH  smallest `a` seen since clear, under the sample's own mode.
- track_valid  output  1  1 once at least one sample has been accepted since clear or reset.
- gt_count  output  CNT_W  number of accepted pairs with A > B, saturating.
- eq_count  output  CNT_W  number of accepted pairs with A == B, saturating.

## Operation
- **Compare:**
  - Signed mode: the MSB is the sign.
  - Negative vs non-negative decides the result directly; otherwise compare the remaining magnitude bits.
  - Unsigned mode: plain binary compare.
  - Exactly one of gt/eq/lt is 1 per valid result.
- **Flag hold:** flags update only on an accepted pair (in_valid=1). Otherwise they hold their last value. out_valid is 0 on cycles with no accepted pair.
- **Tracker update on an accepted pair:**
  - If track_valid=0, load max_a = min_a = a.
  - Otherwise compare a against max_a and min_a using the current sample's signed_mode.
  - Replace max_a only if strictly greater; replace min_a only if strictly smaller.
- **Counters:** gt_count increments on accepted gt; eq_count increments on accepted eq. Both saturate at 2^CNT_W−1 and do not wrap.
- **clear:**
  - Clear without in_valid: track_valid=0, max_a=min_a=0, counters 0.
  - clear with in_valid in the same cycle: the tracker and counters restart from that sample. max_a=min_a=a, track_valid=1, and each counter becomes 1 or 0 according to this pair's result.
  - Compare flags and out_valid are unaffected by clear.
- **Mode switching:** a mode change between samples is legal. Stored extremes are reinterpreted under the new sample's mode; they are not rescaled.

## Timing
- Latency: in_valid at edge N produces out_valid=1 and flags valid after edge N+1 (one register stage). Tracker and counters also reflect sample N after edge N+1.
- Throughput: one pair per cycle, with no backpressure.
- Back-to-back valid inputs produce back-to-back out_valid pulses.
- Reset (async assert, any time, including mid-stream): out_valid=0, a_gt_b=0, a_eq_b=0, a_lt_b=0, max_a=0, min_a=0, track_valid=0, gt_count=0, eq_count=0.
  - A sample in flight during reset is discarded.
  - Release is synchronous to clk; the first edge after deassertion may accept a sample.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert rst mid-stream with in_valid=1 -> all outputs 0 immediately. No out_valid on the cycle after release unless a new sample is driven.
- **Signed vs unsigned (WIDTH=8):**
  - a=8'h80, b=8'h01, signed_mode=1 -> a_lt_b=1 next cycle.
  - Same operands, signed_mode=0 -> a_gt_b=1.
  - a=b=8'hFF -> a_eq_b=1 in both modes.
- **Tracker:** after clear, unsigned a stream 5, 200, 3, 200 -> max_a=200, min_a=3, track_valid=1. gt/eq counts match the driven b values.
- **Saturation (CNT_W=2):** five consecutive pairs with a>b -> gt_count goes 1, 2, 3, 3, 3.
- **clear with in_valid:** after several samples, drive clear=1, in_valid=1, a=b=7 -> next cycle max_a=min_a=7, eq_count=1, gt_count=0, a_eq_b=1, out_valid=1.
- **Gaps:** valid, idle, idle, valid -> out_valid pulses only one cycle after each valid. Flags hold through the idle cycles.

Source files
------------

// File: rtl/comp_track_param.sv
// Registered magnitude comparator with runtime signed/unsigned mode, plus a
// running min/max tracker on operand A and saturating gt/eq event counters.
module comp_track_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clear,
  output logic             out_valid,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic [WIDTH-1:0] max_a,
  output logic [WIDTH-1:0] min_a,
  output logic             track_valid,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] eq_count
);

  localparam int MSB = WIDTH - 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  // Differing MSBs settle the compare directly: in signed mode the operand with
  // the clear sign bit wins, in unsigned mode the one with the set MSB wins.
  function automatic logic isGreater(input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y,
                                     input logic             signedCmp);
    if (x[MSB] != y[MSB])
      return signedCmp ? y[MSB] : x[MSB];
    else
      return x[MSB-1:0] > y[MSB-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] countNext(input logic [CNT_W-1:0] cnt,
                                                 input logic             hit,
                                                 input logic             restart);
    if (restart)
      return hit ? CntMax'(1) & CntMax : '0;
    else if (hit && cnt != CntMax)
      return cnt + 1'b1;
    else
      return cnt;
  endfunction

  logic             pairGt;
  logic             pairEq;
  logic             pairLt;
  logic             newMax;
  logic             newMin;
  logic [WIDTH-1:0] maxNext;
  logic [WIDTH-1:0] minNext;
  logic             trackNext;
  logic [CNT_W-1:0] gtNext;
  logic [CNT_W-1:0] eqNext;

  always_comb begin
    pairGt = isGreater(a, b, signed_mode);
    pairEq = (a == b);
    pairLt = !pairGt && !pairEq;
    newMax = isGreater(a, max_a, signed_mode);
    newMin = isGreater(min_a, a, signed_mode);
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    maxNext   = max_a;
    minNext   = min_a;
    trackNext = track_valid;
    gtNext    = gt_count;
    eqNext    = eq_count;
    if (in_valid) begin
      trackNext = 1'b1;
      gtNext    = countNext(gt_count, pairGt, clear);
      eqNext    = countNext(eq_count, pairEq, clear);
      if (clear || !track_valid) begin
        maxNext = a;
        minNext = a;
      end else begin
        if (newMax) maxNext = a;
        if (newMin) minNext = a;
      end
    end else if (clear) begin
      maxNext   = '0;
      minNext   = '0;
      trackNext = 1'b0;
      gtNext    = '0;
      eqNext    = '0;
    end
  end

  // Compare flags: clear never touches them; they hold between accepted pairs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_valid <= in_valid;
      if (in_valid) begin
        a_gt_b <= pairGt;
        a_eq_b <= pairEq;
        a_lt_b <= pairLt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_a       <= '0;
      min_a       <= '0;
      track_valid <= 1'b0;
      gt_count    <= '0;
      eq_count    <= '0;
    end else begin
      max_a       <= maxNext;
      min_a       <= minNext;
      track_valid <= trackNext;
      gt_count    <= gtNext;
      eq_count    <= eqNext;
    end
  end

endmodule
